mf_frame_scheduler: RTL and testbench
=====================================

MF_FRAME_SCHEDULER -- requirements
Module: mf_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_RES_X, default 1920, active pixels per line.
REQ-002 SHALL have parameter FRAME_RES_Y, default 1080, active lines per frame.
REQ-003 SHALL have parameter FRAME_CNT_WIDTH, default 16, width of the frame counter.
REQ-004 SHALL have ports in this order:
- clk_i, input, 1: single clock.
- rst_n_i, input, 1: reset, synchronous, active-low.
- en_req_i, input, 1: requested median filter enable, from the register side.
- err_clr_i, input, 1: one-cycle pulse; clears the sticky error flags.
- tvalid_i, input, 1: tap of the monitored stream's tvalid.
- tready_i, input, 1: tap of the monitored stream's tready.
- tuser_i, input, 1: tap of tuser; marks start of frame (SOF).
- tlast_i, input, 1: tap of tlast; marks end of line (EOL).
- mf_en_o, output, 1: enable driven into mf_ctrl_if.en.
- en_ack_o, output, 1: one-cycle pulse when a new enable value is applied.
- locked_o, output, 1: high while in state LOCKED.
- frame_cnt_o, output, FRAME_CNT_WIDTH: count of completed good frames.
- err_line_o, output, 1: sticky flag, line length error.
- err_frame_o, output, 1: sticky flag, frame height error.
- err_sof_o, output, 1: sticky flag, SOF received mid-line.

Function
REQ-005 SHALL define beat = tvalid_i & tready_i; inputs are ignored on non-beat cycles.
REQ-006 SHALL keep x_cnt (0..FRAME_RES_X-1) and y_cnt (0..FRAME_RES_Y), each sized $clog2(max+1).
REQ-007 SHALL implement three states:
- SEARCH: waits for a SOF beat.
- LOCKED: tracking a frame.
- RESYNC: after an error, waits for the next SOF.
REQ-008 SOF beat in any state SHALL set x_cnt=1 (x_cnt=0 if that beat also has tlast) and y_cnt=0, and enter LOCKED.
REQ-009 SHALL sample en_req_i only on a SOF beat: mf_en_o takes the new value at the next edge; en_ack_o pulses in that same cycle only if the value changed.
REQ-010 en_req_i changes between SOFs SHALL NOT alter mf_en_o; the last value sampled is applied.
REQ-011 In LOCKED, a non-SOF beat without tlast SHALL increment x_cnt.
REQ-012 In LOCKED, a tlast beat with x_cnt == FRAME_RES_X-1 SHALL zero x_cnt and increment y_cnt.
REQ-013 In LOCKED, a tlast beat with x_cnt != FRAME_RES_X-1 SHALL set err_line_o and go to RESYNC.
REQ-014 In LOCKED, a non-tlast beat with x_cnt == FRAME_RES_X-1 SHALL set err_line_o and go to RESYNC (line too long).
REQ-015 In LOCKED, a beat arriving with y_cnt == FRAME_RES_Y SHALL set err_frame_o and go to RESYNC, unless it is a SOF beat.
REQ-016 On a SOF beat in LOCKED, SHALL increment frame_cnt_o if y_cnt == FRAME_RES_Y and x_cnt == 0; otherwise SHALL set err_frame_o.
REQ-017 A SOF beat with x_cnt != 0 SHALL additionally set err_sof_o; the SOF beat still resynchronises per REQ-008.
REQ-018 In SEARCH and RESYNC, non-SOF beats SHALL be ignored; counters hold.
REQ-019 frame_cnt_o SHALL wrap modulo 2^FRAME_CNT_WIDTH.
REQ-020 Sticky flags SHALL clear on err_clr_i; if an error and err_clr_i occur in the same cycle, set wins.
REQ-021 All outputs SHALL be registered; an error flag rises one cycle after its offending beat.

Reset
REQ-022 On rst_n_i = 0 at a clock edge:
- state goes to SEARCH;
- x_cnt, y_cnt, frame_cnt_o = 0;
- mf_en_o, en_ack_o, locked_o and all error flags = 0.
REQ-023 Reset mid-frame SHALL discard the partial frame; the first SOF after reset applies en_req_i.

Structure
REQ-024 SHALL place the state enum (SEARCH/LOCKED/RESYNC) and counter-width functions in shared package mf_ctrl_pkg.
REQ-025 SHALL be a single module with no sub-modules; the counters and FSM are inline.

Verification
REQ-026 Stimulus: FRAME_RES_X=8, FRAME_RES_Y=4, three clean frames, en_req_i=1 before first SOF -> mf_en_o=1 and en_ack_o pulse one cycle after the first SOF beat; frame_cnt_o=2 after the third SOF; no errors.
REQ-027 Stimulus: toggle en_req_i mid-frame -> mf_en_o is unchanged until the next SOF beat and changes exactly one cycle after it.
REQ-028 Stimulus: line of 7 beats with tlast -> err_line_o=1 one cycle later, locked_o=0; next SOF -> locked_o=1, err_line_o stays 1 until err_clr_i.
REQ-029 Stimulus: SOF at x_cnt=3 -> err_sof_o=1 and err_frame_o=1; frame_cnt_o unchanged; new frame tracked cleanly.
REQ-030 Stimulus: tvalid_i=1, tready_i=0 for 10 cycles with tlast/tuser asserted -> no state or counter change.
REQ-031 Stimulus: rst_n_i low for 1 cycle mid-line, then err_clr_i coincident with an error -> all outputs 0 after reset; the flag reads 1 (set wins).

Source files
------------

// File: rtl/mf_ctrl_pkg.sv
// Shared types and helpers for the median-filter frame scheduler.
package mf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_RESYNC = 2'd2
    } sched_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mf_frame_scheduler.sv
// Tracks frame geometry on a tapped AXI-Stream and applies the median-filter
// enable only at frame boundaries; flags line, frame and SOF errors.
module mf_frame_scheduler
    import mf_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_RES_X     = 1920,
    parameter int unsigned FRAME_RES_Y     = 1080,
    parameter int unsigned FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       en_req_i,
    input  logic                       err_clr_i,
    input  logic                       tvalid_i,
    input  logic                       tready_i,
    input  logic                       tuser_i,
    input  logic                       tlast_i,
    output logic                       mf_en_o,
    output logic                       en_ack_o,
    output logic                       locked_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
    output logic                       err_line_o,
    output logic                       err_frame_o,
    output logic                       err_sof_o
);

    localparam int unsigned X_W = cnt_width(FRAME_RES_X - 1);
    localparam int unsigned Y_W = cnt_width(FRAME_RES_Y);
    localparam logic [X_W-1:0] X_LAST = X_W'(FRAME_RES_X - 1);
    localparam logic [Y_W-1:0] Y_END  = Y_W'(FRAME_RES_Y);

    sched_state_e   state;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           beat;
    logic           sof;

    assign beat = tvalid_i & tready_i;
    assign sof  = beat & tuser_i;

    // FSM, geometry counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= ST_SEARCH;
            x_cnt       <= '0;
            y_cnt       <= '0;
            frame_cnt_o <= '0;
            mf_en_o     <= 1'b0;
            en_ack_o    <= 1'b0;
            locked_o    <= 1'b0;
            err_line_o  <= 1'b0;
            err_frame_o <= 1'b0;
            err_sof_o   <= 1'b0;
        end else begin
            en_ack_o <= 1'b0;
            // Clear first so that a same-cycle error set below takes priority.
            if (err_clr_i) begin
                err_line_o  <= 1'b0;
                err_frame_o <= 1'b0;
                err_sof_o   <= 1'b0;
            end

            if (sof) begin
                if (state == ST_LOCKED) begin
                    if ((y_cnt == Y_END) && (x_cnt == '0)) begin
                        frame_cnt_o <= frame_cnt_o + FRAME_CNT_WIDTH'(1);
                    end else begin
                        err_frame_o <= 1'b1;
                    end
                    if (x_cnt != '0) begin
                        err_sof_o <= 1'b1;
                    end
                end
                mf_en_o  <= en_req_i;
                en_ack_o <= en_req_i ^ mf_en_o;
                x_cnt    <= tlast_i ? '0 : X_W'(1);
                y_cnt    <= '0;
                state    <= ST_LOCKED;
                locked_o <= 1'b1;
            end else if (beat && (state == ST_LOCKED)) begin
                if (y_cnt == Y_END) begin
                    // Data after the last line but before the next SOF.
                    err_frame_o <= 1'b1;
                    state       <= ST_RESYNC;
                    locked_o    <= 1'b0;
                end else if (x_cnt == X_LAST) begin
                    if (tlast_i) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + Y_W'(1);
                    end else begin
                        err_line_o <= 1'b1;
                        state      <= ST_RESYNC;
                        locked_o   <= 1'b0;
                    end
                end else if (tlast_i) begin
                    err_line_o <= 1'b1;
                    state      <= ST_RESYNC;
                    locked_o   <= 1'b0;
                end else begin
                    x_cnt <= x_cnt + X_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mf_frame_scheduler.sv
// Scoreboard bench for mf_frame_scheduler on a small 8x4 frame.
module tb_mf_frame_scheduler;

    localparam int RX = 8;
    localparam int RY = 4;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_req = 1'b0;
    logic          err_clr = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready = 1'b0;
    logic          tuser = 1'b0;
    logic          tlast = 1'b0;
    logic          mf_en;
    logic          en_ack;
    logic          locked;
    logic [FW-1:0] frame_cnt;
    logic          err_line;
    logic          err_frame;
    logic          err_sof;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mf_frame_scheduler #(
        .FRAME_RES_X    (RX),
        .FRAME_RES_Y    (RY),
        .FRAME_CNT_WIDTH(FW)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_req_i   (en_req),
        .err_clr_i  (err_clr),
        .tvalid_i   (tvalid),
        .tready_i   (tready),
        .tuser_i    (tuser),
        .tlast_i    (tlast),
        .mf_en_o    (mf_en),
        .en_ack_o   (en_ack),
        .locked_o   (locked),
        .frame_cnt_o(frame_cnt),
        .err_line_o (err_line),
        .err_frame_o(err_frame),
        .err_sof_o  (err_sof)
    );

    typedef struct {
        logic en, ack, lck, el, ef, es;
        int   fc;
    } exp_t;

    exp_t sb_q[$];

    // Reference state: 0 = search, 1 = locked, 2 = resync.
    int   m_state = 0, m_x = 0, m_y = 0, m_fc = 0;
    logic m_en = 0, m_ack = 0, m_el = 0, m_ef = 0, m_es = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic v, r, u, l, clr, rst);
        logic sl, sf, ss, beat;
        sl = 0; sf = 0; ss = 0;
        beat = v & r;
        if (!rst) begin
            m_state = 0; m_x = 0; m_y = 0; m_fc = 0;
            m_en = 0; m_ack = 0; m_el = 0; m_ef = 0; m_es = 0;
            return;
        end
        m_ack = 0;
        if (beat && u) begin
            if (m_state == 1) begin
                if (m_y == RY && m_x == 0) m_fc = (m_fc + 1) % (1 << FW);
                else sf = 1;
                if (m_x != 0) ss = 1;
            end
            m_ack   = (en_req != m_en);
            m_en    = en_req;
            m_x     = l ? 0 : 1;
            m_y     = 0;
            m_state = 1;
        end else if (beat && m_state == 1) begin
            if (m_y == RY) begin
                sf = 1; m_state = 2;
            end else if (l) begin
                if (m_x == RX - 1) begin m_x = 0; m_y++; end
                else begin sl = 1; m_state = 2; end
            end else if (m_x == RX - 1) begin
                sl = 1; m_state = 2;
            end else begin
                m_x++;
            end
        end
        m_el = (clr ? 1'b0 : m_el) | sl;
        m_ef = (clr ? 1'b0 : m_ef) | sf;
        m_es = (clr ? 1'b0 : m_es) | ss;
    endtask

    // One clock: drive inputs, predict, then compare all outputs after the edge.
    task automatic step(input logic v, r, u, l, input logic clr = 1'b0, input logic rst = 1'b1);
        exp_t e;
        @(negedge clk);
        tvalid = v; tready = r; tuser = u; tlast = l; err_clr = clr; rst_n = rst;
        model_update(v, r, u, l, clr, rst);
        e.en = m_en; e.ack = m_ack; e.lck = (m_state == 1);
        e.el = m_el; e.ef = m_ef; e.es = m_es; e.fc = m_fc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("mf_en", 32'(mf_en), 32'(e.en));
            check_eq("en_ack", 32'(en_ack), 32'(e.ack));
            check_eq("locked", 32'(locked), 32'(e.lck));
            check_eq("frame_cnt", 32'(frame_cnt), 32'(e.fc));
            check_eq("err_line", 32'(err_line), 32'(e.el));
            check_eq("err_frame", 32'(err_frame), 32'(e.ef));
            check_eq("err_sof", 32'(err_sof), 32'(e.es));
        end
    endtask

    task automatic sof_beat();
        step(1, 1, 1, 0);
    endtask

    // n beats of frame body starting at linear position start (1..RX*RY-1).
    task automatic body(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            if ($urandom_range(0, 3) == 0) step(0, 1, 1, 1);
            step(1, 1, 0, (i % RX) == RX - 1);
        end
    endtask

    task automatic full_frame();
        sof_beat();
        body(1, RX * RY - 1);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_mf_en", 32'(mf_en), 32'd0);

        // Three clean frames, enable requested before the first SOF.
        en_req = 1'b1;
        step(0, 0, 0, 0);
        sof_beat();
        check_eq("first_sof_en", 32'(mf_en), 32'd1);
        check_eq("first_sof_ack", 32'(en_ack), 32'd1);
        body(1, RX * RY - 1);
        full_frame();
        sof_beat();
        check_eq("third_sof_cnt", 32'(frame_cnt), 32'd2);
        body(1, RX * RY - 1);
        check_eq("clean_no_err", 32'({err_line, err_frame, err_sof}), 32'd0);

        // Enable change mid-frame is held until the next SOF.
        sof_beat();
        body(1, 10);
        en_req = 1'b0;
        body(11, 5);
        check_eq("en_held", 32'(mf_en), 32'd1);
        body(16, RX * RY - 16);
        sof_beat();
        check_eq("en_applied", 32'(mf_en), 32'd0);
        check_eq("en_ack_change", 32'(en_ack), 32'd1);
        check_eq("cnt_after_toggle", 32'(frame_cnt), 32'd4);

        // Short line: tlast on the 7th beat.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        check_eq("short_line_err", 32'(err_line), 32'd1);
        check_eq("short_line_unlock", 32'(locked), 32'd0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        sof_beat();
        check_eq("relock", 32'(locked), 32'd1);
        check_eq("err_line_sticky", 32'(err_line), 32'd1);
        body(1, RX * RY - 1);
        step(0, 0, 0, 0, 1);
        check_eq("err_line_clr", 32'(err_line), 32'd0);

        // SOF at x_cnt = 3.
        sof_beat();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        sof_beat();
        check_eq("early_sof_err", 32'(err_sof), 32'd1);
        check_eq("early_sof_frame", 32'(err_frame), 32'd1);
        check_eq("early_sof_cnt", 32'(frame_cnt), 32'd5);
        body(1, RX * RY - 1);
        sof_beat();
        check_eq("tracked_after_sof", 32'(frame_cnt), 32'd6);
        step(0, 0, 0, 0, 1);

        // Stalled stream with tuser/tlast held high.
        for (int i = 0; i < 10; i++) step(1, 0, 1, 1);
        check_eq("stall_cnt", 32'(frame_cnt), 32'd6);
        check_eq("stall_locked", 32'(locked), 32'd1);
        body(1, RX * RY - 1);
        sof_beat();

        // Line too long: no tlast at the last pixel.
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        check_eq("long_line_err", 32'(err_line), 32'd1);
        step(0, 0, 0, 0, 1);

        // Extra beat after the last line of a frame.
        full_frame();
        step(1, 1, 0, 0);
        check_eq("tall_frame_err", 32'(err_frame), 32'd1);
        check_eq("tall_frame_unlock", 32'(locked), 32'd0);
        step(0, 0, 0, 0, 1);

        // Counter wraps modulo 2^FW.
        full_frame();
        sof_beat();
        check_eq("cnt_wrap", 32'(frame_cnt), 32'd0);

        // Reset mid-line, then clear coincident with an error.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check_eq("rst_mid_all", 32'({mf_en, en_ack, locked, frame_cnt, err_line, err_frame, err_sof}), 32'd0);
        en_req = 1'b1;
        sof_beat();
        check_eq("post_rst_en", 32'(mf_en), 32'd1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 1, 1);
        check_eq("set_wins", 32'(err_line), 32'd1);
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
